// File: rtl/reg_share_arbiter_pkg.sv
// Shared constants, requester index type and grant-to-index helper.
package reg_share_arbiter_pkg;
  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Returns the index of the set bit of a one-hot grant.
  // An all-zero grant maps to 0.
  function automatic req_idx_t gnt2idx(input logic [NUM_REQ-1:0] g);
    gnt2idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (g[i]) gnt2idx = req_idx_t'(i);
  endfunction
endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bundle for the shared register arbiter.
interface reg_share_arbiter_if
  import reg_share_arbiter_pkg::*;
#(
  parameter int W = 8
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] lock;
  logic [W-1:0]       d0, d1, d2, d3;
  logic [NUM_REQ-1:0] gnt;
  logic [W-1:0]       q;
  logic               q_valid;
  req_idx_t           owner;
  logic               locked;

  modport master (output req, lock, d0, d1, d2, d3,
                  input  gnt, q, q_valid, owner, locked);
  modport slave  (input  req, lock, d0, d1, d2, d3,
                  output gnt, q, q_valid, owner, locked);
endinterface

// File: rtl/reg_share_arbiter_en_reg.sv
// Plain enabled storage register with synchronous active-high reset.
module en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // Load on enable; reset clears.
  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/reg_share_arbiter_rr_pick_4.sv
// Combinational 4-way round-robin picker: first set req at or after ptr.
module rr_pick_4
  import reg_share_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  req_idx_t           i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);
  req_idx_t w_idx;
  logic     w_found;

  // Scan ptr, ptr+1, ... with 2-bit wrap; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = i_ptr + req_idx_t'(k);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter with bounded lock sharing one enabled register
// among four requesters.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  reg_share_arbiter_if.slave bus
);
  req_idx_t r_owner, r_ptr;
  logic [3:0] r_hold;
  logic       r_locked, r_valid;

  logic [NUM_REQ-1:0]        w_rr_gnt, w_gnt;
  logic [NUM_REQ-1:0][W-1:0] w_din;
  logic [W-1:0]              w_d;
  req_idx_t                  w_g;
  logic                      w_en, w_lock_hit, w_locked_nxt;
  logic [3:0]                w_hold_nxt;

  rr_pick_4 u_pick (.i_req(bus.req), .i_ptr(r_ptr), .o_gnt(w_rr_gnt));

  // Lock only wins while the owner still requests; otherwise fall to RR.
  assign w_lock_hit = r_locked & bus.req[r_owner];
  assign w_gnt      = rst        ? '0 :
                      w_lock_hit ? (NUM_REQ'(1) << r_owner) : w_rr_gnt;
  assign w_g        = gnt2idx(w_gnt);
  assign w_en       = |w_gnt;
  assign w_din      = {bus.d3, bus.d2, bus.d1, bus.d0};

  // AND-OR data mux keyed by the one-hot grant.
  always_comb begin
    w_d = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_d = w_d | ({W{w_gnt[i]}} & w_din[i]);
  end

  assign w_hold_nxt   = !w_en       ? 4'd0 :
                        w_lock_hit  ? r_hold + 4'd1 : 4'd1;
  assign w_locked_nxt = w_en & bus.lock[w_g] & (w_hold_nxt < 4'(MAX_HOLD));

  // Arbitration state: owner/ptr/valid move only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_hold   <= w_hold_nxt;
      r_locked <= w_locked_nxt;
      if (w_en) begin
        r_owner <= w_g;
        r_ptr   <= w_g + req_idx_t'(1);
        r_valid <= 1'b1;
      end
    end
  end

  en_reg #(.W(W)) u_reg (
    .clk (clk),
    .rst (rst),
    .i_en(w_en),
    .i_d (w_d),
    .o_q (bus.q)
  );

  assign bus.gnt     = w_gnt;
  assign bus.q_valid = r_valid;
  assign bus.owner   = r_owner;
  assign bus.locked  = r_locked;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration rules.
module tb_reg_share_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_share_arbiter_if #(.W(8)) bus ();

  reg_share_arbiter #(.W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_q, m_valid, m_owner, m_ptr, m_hold, m_locked;

  function automatic int dsel(input int i);
    case (i)
      0: return int'(bus.d0);
      1: return int'(bus.d1);
      2: return int'(bus.d2);
      default: return int'(bus.d3);
    endcase
  endfunction

  // Expected grant for the current inputs and model state.
  function automatic void model_eval(output logic [3:0] g, output int gi, output bit via);
    g = '0; gi = 0; via = 1'b0;
    if (rst) return;
    if (m_locked != 0 && bus.req[m_owner]) begin
      g = 4'b0001 << m_owner; gi = m_owner; via = 1'b1; return;
    end
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (bus.req[idx]) begin g = 4'b0001 << idx; gi = idx; return; end
    end
  endfunction

  // Advance one clock, updating the model from the held inputs.
  task automatic tick();
    logic [3:0] g; int gi; bit via;
    model_eval(g, gi, via);
    @(posedge clk);
    if (rst) begin
      m_q = 0; m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_locked = 0;
    end else if (g != 0) begin
      m_q = dsel(gi); m_valid = 1; m_owner = gi; m_ptr = (gi + 1) % 4;
      m_hold = via ? m_hold + 1 : 1;
      m_locked = (bus.lock[gi] && m_hold < MAX_HOLD) ? 1 : 0;
    end else begin
      m_hold = 0; m_locked = 0;
    end
    #1;
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] lk,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] e);
    bus.req = rq; bus.lock = lk;
    bus.d0 = a; bus.d1 = b; bus.d2 = c; bus.d3 = e;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0, 4'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      n_tests++;
      if (bus.gnt !== 4'b0 || bus.q !== 8'h00 || bus.q_valid !== 1'b0 ||
          bus.owner !== 2'd0 || bus.locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: gnt=%b q=%h v=%b own=%0d lk=%b, want 0000/00/0/0/0",
                 i, bus.gnt, bus.q, bus.q_valid, bus.owner, bus.locked);
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] eq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int         eo [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0, 8'h11, 8'h22, 8'h33, 8'h44);
      n_tests++;
      if (bus.gnt !== eg[i]) begin
        n_fail++; $display("FAIL rotation_gnt cyc%0d: got %b want %b", i, bus.gnt, eg[i]);
      end
      tick();
      n_tests++;
      if (bus.q !== eq[i] || bus.owner !== 2'(eo[i]) || bus.q_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation_q cyc%0d: q=%h own=%0d v=%b want q=%h own=%0d v=1",
                 i, bus.q, bus.owner, bus.q_valid, eq[i], eo[i]);
      end
    end
  endtask

  task automatic test_lock_limit();
    logic [3:0] eg [6] = '{4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic       el [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(4'b0101, 4'b0100, 8'h5A, 8'h00, 8'hA5, 8'h00);
      n_tests++;
      if (bus.gnt !== eg[i]) begin
        n_fail++; $display("FAIL lock_limit_gnt cyc%0d: got %b want %b", i, bus.gnt, eg[i]);
      end
      tick();
      n_tests++;
      if (bus.locked !== el[i]) begin
        n_fail++; $display("FAIL lock_limit_locked cyc%0d: got %b want %b", i, bus.locked, el[i]);
      end
    end
  endtask

  task automatic test_lock_release();
    do_reset();
    drive(4'b0010, 4'b0010, 8'h00, 8'h77, 8'h00, 8'h99);
    tick();
    n_tests++;
    if (bus.locked !== 1'b1 || bus.owner !== 2'd1) begin
      n_fail++; $display("FAIL release_setup: locked=%b own=%0d want 1/1", bus.locked, bus.owner);
    end
    drive(4'b1000, 4'b0010, 8'h00, 8'h77, 8'h00, 8'h99);
    n_tests++;
    if (bus.gnt !== 4'b1000) begin
      n_fail++; $display("FAIL release_gnt: got %b want 1000", bus.gnt);
    end
    tick();
    n_tests++;
    if (bus.locked !== 1'b0 || bus.owner !== 2'd3 || bus.q !== 8'h99) begin
      n_fail++;
      $display("FAIL release_after: locked=%b own=%0d q=%h want 0/3/99", bus.locked, bus.owner, bus.q);
    end
  endtask

  task automatic test_reset_midlock();
    do_reset();
    drive(4'b0100, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    tick(); tick();
    n_tests++;
    if (bus.locked !== 1'b1 || bus.q !== 8'hA5) begin
      n_fail++; $display("FAIL midlock_setup: locked=%b q=%h want 1/a5", bus.locked, bus.q);
    end
    rst = 1'b1;
    drive(4'b1111, 4'b0100, 8'h11, 8'h22, 8'h33, 8'h44);
    n_tests++;
    if (bus.gnt !== 4'b0000) begin
      n_fail++; $display("FAIL midlock_rst_gnt: got %b want 0000", bus.gnt);
    end
    tick();
    rst = 1'b0;
    drive(4'b1111, 4'b0100, 8'h11, 8'h22, 8'h33, 8'h44);
    n_tests++;
    if (bus.q !== 8'h00 || bus.locked !== 1'b0 || bus.q_valid !== 1'b0 || bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midlock_after: q=%h locked=%b v=%b gnt=%b want 00/0/0/0001",
               bus.q, bus.locked, bus.q_valid, bus.gnt);
    end
    tick();
  endtask

  task automatic test_single();
    logic [7:0] dv [3] = '{8'h01, 8'h02, 8'h03};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1000, 4'b0, 8'h00, 8'h00, 8'h00, dv[i]);
      n_tests++;
      if (bus.gnt !== 4'b1000) begin
        n_fail++; $display("FAIL single_gnt cyc%0d: got %b want 1000", i, bus.gnt);
      end
      tick();
      n_tests++;
      if (bus.q !== dv[i]) begin
        n_fail++; $display("FAIL single_q cyc%0d: got %h want %h", i, bus.q, dv[i]);
      end
    end
    drive(4'b1111, 4'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    n_tests++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL single_wrap: got %b want 0001", bus.gnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] g; int gi; bit via;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      model_eval(g, gi, via);
      n_tests++;
      if (bus.gnt !== g || bus.q !== 8'(m_q) || bus.q_valid !== 1'(m_valid) ||
          bus.owner !== 2'(m_owner) || bus.locked !== 1'(m_locked)) begin
        n_fail++;
        $display("FAIL random cyc%0d: gnt=%b q=%h v=%b own=%0d lk=%b want %b/%h/%0d/%0d/%0d",
                 i, bus.gnt, bus.q, bus.q_valid, bus.owner, bus.locked,
                 g, 8'(m_q), m_valid, m_owner, m_locked);
      end
      n_tests++;
      if (!$onehot0(bus.gnt)) begin
        n_fail++; $display("FAIL random_onehot cyc%0d: gnt=%b want one-hot or zero", i, bus.gnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.lock = '0;
    bus.d0 = '0; bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
    m_q = 0; m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_locked = 0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_lock_limit();
    test_lock_release();
    test_reset_midlock();
    test_single();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
